// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: controller states and the packed
// 4-wide bundle carried from fetch to decode.
package fetch_pkg;

    localparam int FETCH_WIDTH = 4;
    localparam int PC_W        = 16;
    localparam int BUNDLE_W    = 196;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] inst;
        logic [63:0] recv_pc;
        logic [3:0]  pred;
    } bundle_t;

    // Sequential fetch advances by one bundle; wraps naturally at 2^16.
    function automatic logic [PC_W-1:0] seq_next_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(FETCH_WIDTH);
    endfunction

endpackage

// File: rtl/fetch_bundle_q.sv
// Two-entry FIFO of fetch bundles. Entry 0 is always the head; freed or
// cleared entries are zeroed so the decode-facing fields read 0 when empty.
module fetch_bundle_q
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic        pop,
    input  bundle_t     din,
    output bundle_t     head,
    output logic [1:0]  count
);

    bundle_t ent0;
    bundle_t ent1;
    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        ent0 <= din;
                        cnt  <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        ent1 <= din;
                        cnt  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt != 2'd0) begin
                        ent0 <= ent1;
                        ent1 <= '0;
                        cnt  <= cnt - 2'd1;
                    end
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new bundle lands
                    // behind whatever remains after the head leaves.
                    if (cnt == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end else begin
                        ent0 <= din;
                        ent1 <= '0;
                        cnt  <= 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = ent0;
    assign count = cnt;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch-to-decode sequencer: owns the fetch PC, selects the next PC and
// buffers bundles in a 2-entry queue ahead of the decoder.
//
// state | meaning
// IDLE  | one cycle after reset, no fetch
// RUN   | fetching and enqueuing bundles
// FLUSH | one-cycle bubble after a redirect
module fetch_seq_ctrl
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bundle_vld,
    input  logic [63:0]            pc_in,
    input  logic [63:0]            inst_in,
    input  logic [63:0]            recv_pc_in,
    input  logic [3:0]             pred_in,
    input  logic                   jmp_vld,
    input  logic [15:0]            jmp_addr,
    input  logic                   brnch_taken,
    input  logic [15:0]            brnch_addr,
    input  logic                   mispred_vld,
    input  logic [15:0]            mispred_pc,
    input  logic                   dec_rdy,
    output logic [15:0]            fetch_pc,
    output logic                   dec_vld,
    output logic [63:0]            pc_to_dec,
    output logic [63:0]            inst_to_dec,
    output logic [63:0]            recv_pc_to_dec,
    output logic [3:0]             pred_result_to_dec,
    output logic                   fetch_stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    fetch_state_e state;
    bundle_t      q_din;
    bundle_t      q_head;
    logic [1:0]   q_count;
    logic         deq;
    logic         enq;
    logic         room;
    logic         q_pop;
    logic [15:0]  taken_pc;

    assign dec_vld = (q_count != 2'd0);
    assign deq     = dec_vld && dec_rdy;
    assign room    = (q_count != 2'd2) || deq;
    assign enq     = (state == RUN) && bundle_vld && !mispred_vld && room;
    // A redirect empties the queue on the same edge, so any dequeue is moot.
    assign q_pop   = deq && !mispred_vld;

    assign fetch_stall = (state != RUN) || ((q_count == 2'd2) && !deq);

    assign taken_pc = jmp_vld     ? jmp_addr   :
                      brnch_taken ? brnch_addr :
                                    seq_next_pc(fetch_pc);

    always_comb begin
        q_din         = '0;
        q_din.pc      = pc_in;
        q_din.inst    = inst_in;
        q_din.recv_pc = recv_pc_in;
        q_din.pred    = pred_in;
    end

    fetch_bundle_q u_bundle_q (
        .clk   (clk),
        .rst   (rst),
        .clear (mispred_vld),
        .push  (enq),
        .pop   (q_pop),
        .din   (q_din),
        .head  (q_head),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            stall_cnt <= '0;
        end else begin
            if (mispred_vld) begin
                state    <= FLUSH;
                fetch_pc <= mispred_pc;
            end else begin
                case (state)
                    IDLE:    state <= RUN;
                    RUN:     state <= RUN;
                    FLUSH:   state <= RUN;
                    default: state <= IDLE;
                endcase
                if (enq) begin
                    fetch_pc <= taken_pc;
                end
            end

            if (fetch_stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign pc_to_dec          = q_head.pc;
    assign inst_to_dec        = q_head.inst;
    assign recv_pc_to_dec     = q_head.recv_pc;
    assign pred_result_to_dec = q_head.pred;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: directed scenarios plus random
// traffic, all scored against a queue-based behavioural model.
module tb_fetch_seq_ctrl;

    localparam int          SCW = 4;
    localparam logic [15:0] RPC = 16'h0000;
    localparam int          SAT = (1 << SCW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           bundle_vld;
    logic [63:0]    pc_in;
    logic [63:0]    inst_in;
    logic [63:0]    recv_pc_in;
    logic [3:0]     pred_in;
    logic           jmp_vld;
    logic [15:0]    jmp_addr;
    logic           brnch_taken;
    logic [15:0]    brnch_addr;
    logic           mispred_vld;
    logic [15:0]    mispred_pc;
    logic           dec_rdy;
    logic [15:0]    fetch_pc;
    logic           dec_vld;
    logic [63:0]    pc_to_dec;
    logic [63:0]    inst_to_dec;
    logic [63:0]    recv_pc_to_dec;
    logic [3:0]     pred_result_to_dec;
    logic           fetch_stall;
    logic [SCW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model: PC, FIFO contents, mode (0 idle, 1 running, 2 bubble), stall count
    logic [15:0]  m_pc;
    logic [195:0] m_q[$];
    int           m_mode;
    int           m_stall;

    always #5 clk = ~clk;

    fetch_seq_ctrl #(.RESET_PC(RPC), .STALL_CNT_W(SCW)) dut (
        .clk                (clk),
        .rst                (rst),
        .bundle_vld         (bundle_vld),
        .pc_in              (pc_in),
        .inst_in            (inst_in),
        .recv_pc_in         (recv_pc_in),
        .pred_in            (pred_in),
        .jmp_vld            (jmp_vld),
        .jmp_addr           (jmp_addr),
        .brnch_taken        (brnch_taken),
        .brnch_addr         (brnch_addr),
        .mispred_vld        (mispred_vld),
        .mispred_pc         (mispred_pc),
        .dec_rdy            (dec_rdy),
        .fetch_pc           (fetch_pc),
        .dec_vld            (dec_vld),
        .pc_to_dec          (pc_to_dec),
        .inst_to_dec        (inst_to_dec),
        .recv_pc_to_dec     (recv_pc_to_dec),
        .pred_result_to_dec (pred_result_to_dec),
        .fetch_stall        (fetch_stall),
        .stall_cnt          (stall_cnt)
    );

    function automatic logic [63:0] pcs_of(input logic [15:0] p);
        logic [15:0] p1, p2, p3;
        p1 = p + 16'd1;
        p2 = p + 16'd2;
        p3 = p + 16'd3;
        return {p, p1, p2, p3};
    endfunction

    task automatic drive_bundle();
        pc_in      = pcs_of(m_pc);
        inst_in    = {$urandom(), $urandom()};
        recv_pc_in = {$urandom(), $urandom()};
        pred_in    = 4'($urandom_range(0, 15));
    endtask

    // One clock: score outputs against the model, then advance the model.
    task automatic tick();
        logic         exp_stall;
        logic         deq;
        logic         enq;
        logic [195:0] got;
        #1;
        exp_stall = (m_mode != 1) || (m_q.size() == 2 && !dec_rdy);
        if (!rst) begin
            checks++;
            if (fetch_pc !== m_pc) begin
                errors++;
                $display("FAIL model_fetch_pc t=%0t got %h want %h", $time, fetch_pc, m_pc);
            end
            checks++;
            if (dec_vld !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL model_dec_vld t=%0t got %b want %b", $time, dec_vld, m_q.size() != 0);
            end
            checks++;
            if (fetch_stall !== exp_stall) begin
                errors++;
                $display("FAIL model_fetch_stall t=%0t got %b want %b", $time, fetch_stall, exp_stall);
            end
            checks++;
            if (int'(stall_cnt) != m_stall) begin
                errors++;
                $display("FAIL model_stall_cnt t=%0t got %0d want %0d", $time, stall_cnt, m_stall);
            end
            if (m_q.size() != 0) begin
                got = {pc_to_dec, inst_to_dec, recv_pc_to_dec, pred_result_to_dec};
                checks++;
                if (got !== m_q[0]) begin
                    errors++;
                    $display("FAIL model_head t=%0t got %h want %h", $time, got, m_q[0]);
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            m_pc    = RPC;
            m_q.delete();
            m_mode  = 0;
            m_stall = 0;
        end else begin
            deq = (m_q.size() != 0) && dec_rdy;
            if (exp_stall && m_stall < SAT) m_stall++;
            if (mispred_vld) begin
                m_q.delete();
                m_pc   = mispred_pc;
                m_mode = 2;
            end else begin
                enq = (m_mode == 1) && bundle_vld && (m_q.size() < 2 || deq);
                if (deq) void'(m_q.pop_front());
                if (enq) begin
                    m_q.push_back({pc_in, inst_in, recv_pc_in, pred_in});
                    m_pc = jmp_vld ? jmp_addr : brnch_taken ? brnch_addr : m_pc + 16'd4;
                end
                m_mode = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bundle_vld  = 1'b0;
        jmp_vld     = 1'b0;
        jmp_addr    = '0;
        brnch_taken = 1'b0;
        brnch_addr  = '0;
        mispred_vld = 1'b0;
        mispred_pc  = '0;
        dec_rdy     = 1'b0;
        pc_in       = '0;
        inst_in     = '0;
        recv_pc_in  = '0;
        pred_in     = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (fetch_pc !== RPC) begin
            errors++; $display("FAIL reset_fetch_pc got %h want %h", fetch_pc, RPC);
        end
        checks++;
        if (dec_vld !== 1'b0) begin
            errors++; $display("FAIL reset_dec_vld got %b want 0", dec_vld);
        end
        checks++;
        if ({pc_to_dec, inst_to_dec, recv_pc_to_dec, pred_result_to_dec} !== 196'd0) begin
            errors++; $display("FAIL reset_head got %h want 0", pc_to_dec);
        end
        checks++;
        if (fetch_stall !== 1'b1 || stall_cnt !== '0) begin
            errors++; $display("FAIL reset_stall got %b/%0d want 1/0", fetch_stall, stall_cnt);
        end
    endtask

    task automatic test_seq_fetch();
        logic [15:0] exp_pc[4];
        exp_pc = '{16'h0000, 16'h0000, 16'h0004, 16'h0008};
        do_reset();
        bundle_vld = 1'b1;
        dec_rdy    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_bundle();
            #1;
            checks++;
            if (fetch_pc !== exp_pc[i]) begin
                errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, fetch_pc, exp_pc[i]);
            end
            checks++;
            if (dec_vld !== (i >= 2)) begin
                errors++; $display("FAIL seq_dec_vld[%0d] got %b want %b", i, dec_vld, i >= 2);
            end
            if (i == 2) begin
                checks++;
                if (pc_to_dec !== 64'h0000_0001_0002_0003) begin
                    errors++; $display("FAIL seq_first_pc got %h want 0000000100020003", pc_to_dec);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch_prio();
        jmp_vld     = 1'b1;
        jmp_addr    = 16'h0040;
        brnch_taken = 1'b1;
        brnch_addr  = 16'h0080;
        drive_bundle();
        tick();
        #1;
        checks++;
        if (fetch_pc !== 16'h0040) begin
            errors++; $display("FAIL jmp_over_brnch got %h want 0040", fetch_pc);
        end
        jmp_vld = 1'b0;
        drive_bundle();
        tick();
        #1;
        checks++;
        if (fetch_pc !== 16'h0080) begin
            errors++; $display("FAIL brnch_taken got %h want 0080", fetch_pc);
        end
        brnch_taken = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        bundle_vld = 1'b1;
        dec_rdy    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_bundle();
            tick();
        end
        #1;
        checks++;
        if (fetch_pc !== 16'h0008) begin
            errors++; $display("FAIL bp_hold_pc got %h want 0008", fetch_pc);
        end
        checks++;
        if (stall_cnt !== SCW'(4)) begin
            errors++; $display("FAIL bp_stall_cnt got %0d want 4", stall_cnt);
        end
        checks++;
        if (pc_to_dec !== 64'h0000_0001_0002_0003) begin
            errors++; $display("FAIL bp_head0 got %h want 0000000100020003", pc_to_dec);
        end
        dec_rdy = 1'b1;
        drive_bundle();
        #1;
        checks++;
        if (fetch_stall !== 1'b0) begin
            errors++; $display("FAIL bp_full_deq_stall got %b want 0", fetch_stall);
        end
        tick();
        #1;
        checks++;
        if (pc_to_dec !== 64'h0004_0005_0006_0007 || fetch_pc !== 16'h000C) begin
            errors++; $display("FAIL bp_head1 got %h/%h want 0004000500060007/000c", pc_to_dec, fetch_pc);
        end
    endtask

    task automatic test_mispred_full();
        bundle_vld = 1'b1;
        dec_rdy    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_bundle();
            tick();
        end
        mispred_vld = 1'b1;
        mispred_pc  = 16'h0123;
        dec_rdy     = 1'b1;
        drive_bundle();
        tick();
        mispred_vld = 1'b0;
        #1;
        checks++;
        if (dec_vld !== 1'b0 || fetch_pc !== 16'h0123) begin
            errors++; $display("FAIL redirect got vld=%b pc=%h want vld=0 pc=0123", dec_vld, fetch_pc);
        end
        checks++;
        if (fetch_stall !== 1'b1 || pc_to_dec !== 64'd0) begin
            errors++; $display("FAIL flush_bubble got stall=%b head=%h want 1/0", fetch_stall, pc_to_dec);
        end
        drive_bundle();
        tick();
        #1;
        checks++;
        if (dec_vld !== 1'b0 || fetch_stall !== 1'b0) begin
            errors++; $display("FAIL after_flush got vld=%b stall=%b want 0/0", dec_vld, fetch_stall);
        end
        drive_bundle();
        tick();
        #1;
        checks++;
        if (pc_to_dec !== 64'h0123_0124_0125_0126 || fetch_pc !== 16'h0127) begin
            errors++; $display("FAIL new_path got %h/%h want 0123012401250126/0127", pc_to_dec, fetch_pc);
        end
    endtask

    task automatic test_wrap();
        dec_rdy     = 1'b1;
        bundle_vld  = 1'b1;
        mispred_vld = 1'b1;
        mispred_pc  = 16'hFFFC;
        tick();
        mispred_vld = 1'b0;
        drive_bundle();
        tick();
        drive_bundle();
        tick();
        #1;
        checks++;
        if (fetch_pc !== 16'h0000) begin
            errors++; $display("FAIL pc_wrap got %h want 0000", fetch_pc);
        end
        checks++;
        if (pc_to_dec !== 64'hFFFC_FFFD_FFFE_FFFF) begin
            errors++; $display("FAIL wrap_head got %h want fffcfffdfffeffff", pc_to_dec);
        end
    endtask

    task automatic test_stall_saturate();
        bundle_vld = 1'b1;
        dec_rdy    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_bundle();
            tick();
        end
        #1;
        checks++;
        if (stall_cnt !== SCW'(SAT)) begin
            errors++; $display("FAIL stall_saturate got %0d want %0d", stall_cnt, SAT);
        end
    endtask

    task automatic test_rst_override();
        bundle_vld = 1'b1;
        dec_rdy    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_bundle();
            tick();
        end
        rst         = 1'b1;
        mispred_vld = 1'b1;
        mispred_pc  = 16'h0555;
        tick();
        rst         = 1'b0;
        mispred_vld = 1'b0;
        bundle_vld  = 1'b0;
        #1;
        checks++;
        if (fetch_pc !== RPC || dec_vld !== 1'b0) begin
            errors++; $display("FAIL rst_override got pc=%h vld=%b want %h/0", fetch_pc, dec_vld, RPC);
        end
        checks++;
        if (stall_cnt !== '0 || pc_to_dec !== 64'd0 || fetch_stall !== 1'b1) begin
            errors++; $display("FAIL rst_override_clr got cnt=%0d head=%h stall=%b want 0/0/1",
                               stall_cnt, pc_to_dec, fetch_stall);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bundle_vld  = ($urandom_range(0, 3) != 0);
            dec_rdy     = ($urandom_range(0, 2) != 0);
            jmp_vld     = ($urandom_range(0, 7) == 0);
            jmp_addr    = 16'($urandom());
            brnch_taken = ($urandom_range(0, 5) == 0);
            brnch_addr  = 16'($urandom());
            mispred_vld = ($urandom_range(0, 19) == 0);
            mispred_pc  = 16'($urandom());
            drive_bundle();
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        m_pc    = RPC;
        m_mode  = 0;
        m_stall = 0;
        rst     = 1'b1;
        clear_inputs();
        test_reset();
        test_seq_fetch();
        test_branch_prio();
        test_backpressure();
        test_mispred_full();
        test_wrap();
        test_stall_saturate();
        test_rst_override();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
